// File: rtl/switch_led_ctrl.sv
// Debounced switch bank driving a registered LED bank in direct, toggle, counter or walking-light mode.
// Define SWITCH_LED_SYNC_EN to put a 2-FF synchroniser in front of the debouncer.
module switch_led_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STEP_CYCLES     = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switch,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic [WIDTH-1:0] sw_db
);

  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [WIDTH-1:0]  LED_ONE   = WIDTH'(1);

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'd0,
    MODE_TOGGLE  = 2'd1,
    MODE_COUNTER = 2'd2,
    MODE_WALK    = 2'd3
  } mode_e;

  logic [WIDTH-1:0]  w_raw;
  logic [CNT_W-1:0]  r_cnt [WIDTH];
  logic [WIDTH-1:0]  r_swDb;
  logic [WIDTH-1:0]  r_rise;
  logic [WIDTH-1:0]  r_led;
  logic [1:0]        r_modeQ;
  logic [STEP_W-1:0] r_step;
  mode_e             w_mode;

`ifdef SWITCH_LED_SYNC_EN
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= switch;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw = r_sync2;
`else
  assign w_raw = switch;
`endif

  // A bit is accepted only after DEBOUNCE_CYCLES consecutive samples that disagree with sw_db.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_swDb <= '0;
      r_rise <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_rise[i] <= 1'b0;
        if (w_raw[i] == r_swDb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_cnt[i]  <= '0;
          r_swDb[i] <= w_raw[i];
          r_rise[i] <= w_raw[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign w_mode = mode_e'(mode);

  // A mode change reloads the LEDs and suppresses that cycle's normal update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led   <= '0;
      r_modeQ <= '0;
      r_step  <= '0;
    end else begin
      r_modeQ <= mode;
      if (mode != r_modeQ) begin
        r_step <= '0;
        case (w_mode)
          MODE_DIRECT:  r_led <= r_swDb;
          MODE_WALK:    r_led <= LED_ONE;
          default:      r_led <= '0;
        endcase
      end else begin
        r_step <= '0;
        case (w_mode)
          MODE_DIRECT:  r_led <= r_swDb;
          MODE_TOGGLE:  r_led <= r_led ^ r_rise;
          MODE_COUNTER: begin
            if (r_rise[0]) begin
              r_led <= r_led + LED_ONE;
            end
          end
          MODE_WALK: begin
            if (r_step == STEP_LAST) begin
              if (r_swDb[0]) begin
                r_led <= {r_led[0], r_led[WIDTH-1:1]};
              end else begin
                r_led <= {r_led[WIDTH-2:0], r_led[WIDTH-1]};
              end
            end else begin
              r_step <= r_step + STEP_ONE;
            end
          end
          default: r_led <= r_led;
        endcase
      end
    end
  end

  assign led   = r_led;
  assign sw_db = r_swDb;

endmodule
